// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 sound-side bus sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package z80_bus_pkg;

    localparam int DEF_CLK_DIV = 6;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/z80_region_dec.sv
// Priority address-region matcher: returns hit flag and the selected wait-state minimum.
// Latency: combinational.
// Backpressure: none; pure decode.
module z80_region_dec
    import z80_bus_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int WS_W        = 4
) (
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [ADDR_W*NUM_REGIONS-1:0] i_base,
    input  logic [ADDR_W*NUM_REGIONS-1:0] i_mask,
    input  logic [WS_W*NUM_REGIONS-1:0]   i_ws,
    output logic                          o_hit,
    output logic [WS_W-1:0]               o_ws
);

    // Scan from the highest index down so the lowest matching region overwrites last and wins.
    always_comb begin
        o_hit = 1'b0;
        o_ws  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((i_addr & i_mask[i*ADDR_W +: ADDR_W]) ==
                (i_base[i*ADDR_W +: ADDR_W] & i_mask[i*ADDR_W +: ADDR_W])) begin
                o_hit = 1'b1;
                o_ws  = i_ws[i*WS_W +: WS_W];
            end
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 bus sequencer: CPU clock enables, refresh masking, one req/ack memory transaction per access.
// Latency: start 1 cycle after strobes; MEM_REQ/nWAIT 1 cycle after start; nWAIT release 1 cycle after ACK/count done.
// Backpressure: CPU is stalled via nWAIT until both MEM_ACK and the region's minimum wait count are satisfied.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int NUM_REGIONS = 2,
    parameter int WS_W        = 4
) (
    input  logic                          CLK_24M,
    input  logic                          nRESET,
    output logic                          CLK_P_EN,
    output logic                          CLK_N_EN,
    input  logic [ADDR_W-1:0]             SDA,
    input  logic                          MREQ_n,
    input  logic                          RFSH_n,
    input  logic                          nRD,
    input  logic                          nWR,
    input  logic [DATA_W-1:0]             SDD_OUT,
    output logic [DATA_W-1:0]             SDD_IN,
    output logic                          nMREQ,
    output logic                          nWAIT,
    input  logic [ADDR_W*NUM_REGIONS-1:0] REGION_BASE,
    input  logic [ADDR_W*NUM_REGIONS-1:0] REGION_MASK,
    input  logic [WS_W*NUM_REGIONS-1:0]   REGION_WS,
    output logic                          MEM_REQ,
    output logic                          MEM_WE,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic [DATA_W-1:0]             MEM_WDATA,
    input  logic                          MEM_ACK,
    input  logic [DATA_W-1:0]             MEM_RDATA
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0]     r_div;
    logic              r_p_en;
    logic              r_n_en;
    logic              r_access;
    logic              r_access_d;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WS_W-1:0]   r_ws;
    logic [WS_W-1:0]   w_ws_nxt;
    logic [WS_W-1:0]   w_ws_dec;
    logic              r_mem_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_nwait;
    logic              w_access_raw;
    logic              w_start;
    logic              w_hit;
    logic [WS_W-1:0]   w_reg_ws;
    logic [WS_W-1:0]   w_ws_sel;

    // Refresh cycles drive MREQ_n low too; hide them from the memory side.
    assign nMREQ        = MREQ_n | ~RFSH_n;
    assign w_access_raw = ~nMREQ & (~nRD | ~nWR);
    assign w_start      = r_access & ~r_access_d;

    z80_region_dec #(
        .NUM_REGIONS (NUM_REGIONS),
        .WS_W        (WS_W)
    ) u_region_dec (
        .i_addr (SDA),
        .i_base (REGION_BASE),
        .i_mask (REGION_MASK),
        .i_ws   (REGION_WS),
        .o_hit  (w_hit),
        .o_ws   (w_reg_ws)
    );

    assign w_ws_sel = w_hit ? w_reg_ws : '0;

    // Free-running divider; enables are registered so they stay low through reset.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_div  <= '0;
            r_p_en <= 1'b0;
            r_n_en <= 1'b0;
        end else begin
            r_div  <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
            r_p_en <= (r_div == '0);
            r_n_en <= (r_div == DW'(CLK_DIV / 2));
        end
    end

    // Input register for the access condition and its delayed copy for edge detection.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_access   <= 1'b0;
            r_access_d <= 1'b0;
        end else begin
            r_access   <= w_access_raw;
            r_access_d <= r_access;
        end
    end

    // Next-state and wait-count: the minimum runs down on CLK_P_EN while the memory request is outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_ws_nxt    = r_ws;
        w_ws_dec    = (r_p_en && (r_ws != '0)) ? r_ws - WS_W'(1) : r_ws;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = REQ;
                    w_ws_nxt    = w_ws_sel;
                end
            end
            REQ: begin
                w_ws_nxt = w_ws_dec;
                if (MEM_ACK) begin
                    w_state_nxt = (w_ws_dec == '0) ? DONE : HOLD;
                end
            end
            HOLD: begin
                w_ws_nxt = w_ws_dec;
                if (w_ws_dec == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!r_access) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, count and registered bus outputs; MEM_REQ and nWAIT follow the next state.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= IDLE;
            r_ws      <= '0;
            r_mem_req <= 1'b0;
            r_nwait   <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= 8'hFF;
        end else begin
            r_state   <= w_state_nxt;
            r_ws      <= w_ws_nxt;
            r_mem_req <= (w_state_nxt == REQ);
            r_nwait   <= !((w_state_nxt == REQ) || (w_state_nxt == HOLD));
            if ((r_state == IDLE) && w_start) begin
                r_addr  <= SDA;
                r_wdata <= SDD_OUT;
                r_we    <= ~nWR;
            end
            if ((r_state == REQ) && MEM_ACK && !r_we) begin
                r_rdata <= MEM_RDATA;
            end
        end
    end

    assign CLK_P_EN  = r_p_en;
    assign CLK_N_EN  = r_n_en;
    assign MEM_REQ   = r_mem_req;
    assign MEM_WE    = r_we;
    assign MEM_ADDR  = r_addr;
    assign MEM_WDATA = r_wdata;
    assign SDD_IN    = r_rdata;
    assign nWAIT     = r_nwait;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed bench for z80_bus_ctrl: divider phases, refresh masking, wait-state and priority behaviour, reset abort.
// Latency: n/a.
// Backpressure: bench drives MEM_ACK at chosen points relative to MEM_REQ / CLK_P_EN.
module tb_z80_bus_ctrl;

    logic        CLK_24M = 1'b0;
    logic        nRESET  = 1'b0;
    logic        CLK_P_EN, CLK_N_EN;
    logic [15:0] SDA     = 16'h0000;
    logic        MREQ_n  = 1'b1;
    logic        RFSH_n  = 1'b1;
    logic        nRD     = 1'b1;
    logic        nWR     = 1'b1;
    logic [7:0]  SDD_OUT = 8'h00;
    logic [7:0]  SDD_IN;
    logic        nMREQ, nWAIT;
    logic [31:0] REGION_BASE;
    logic [31:0] REGION_MASK;
    logic [7:0]  REGION_WS;
    logic        MEM_REQ, MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_ACK   = 1'b0;
    logic [7:0]  MEM_RDATA = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK_24M = ~CLK_24M;

    z80_bus_ctrl #(.CLK_DIV(6), .NUM_REGIONS(2), .WS_W(4)) dut (
        .CLK_24M     (CLK_24M),
        .nRESET      (nRESET),
        .CLK_P_EN    (CLK_P_EN),
        .CLK_N_EN    (CLK_N_EN),
        .SDA         (SDA),
        .MREQ_n      (MREQ_n),
        .RFSH_n      (RFSH_n),
        .nRD         (nRD),
        .nWR         (nWR),
        .SDD_OUT     (SDD_OUT),
        .SDD_IN      (SDD_IN),
        .nMREQ       (nMREQ),
        .nWAIT       (nWAIT),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_WS   (REGION_WS),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One CPU memory access. ack_dly >= 0: ACK on that negedge index after MEM_REQ is seen;
    // ack_dly < 0: ACK on the first CLK_P_EN seen while nWAIT is low.
    task automatic run_txn(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                           input int ack_dly, input logic [7:0] rdata,
                           output int low_cyc, output int pulses, output logic last_p);
        int  t;
        int  idx;
        bit  ack_sent;
        @(negedge CLK_24M);
        SDA = addr; SDD_OUT = wdata; RFSH_n = 1'b1; MREQ_n = 1'b0;
        nRD = we; nWR = !we;
        t = 0;
        while (!MEM_REQ && t < 20) begin
            @(negedge CLK_24M);
            t++;
        end
        check_eq("req_seen", {31'd0, MEM_REQ}, 32'd1);
        low_cyc = 0; pulses = 0; last_p = 1'b0; idx = 0; ack_sent = 0;
        while (!nWAIT && t < 200) begin
            low_cyc++;
            if (CLK_P_EN) pulses++;
            last_p = CLK_P_EN;
            if (!ack_sent && ((ack_dly >= 0 && idx == ack_dly) || (ack_dly < 0 && CLK_P_EN))) begin
                MEM_ACK = 1'b1; MEM_RDATA = rdata; ack_sent = 1;
            end else begin
                MEM_ACK = 1'b0;
            end
            idx++;
            @(negedge CLK_24M);
            t++;
        end
        MEM_ACK = 1'b0;
        check_eq("wait_released", {31'd0, nWAIT}, 32'd1);
        check_eq("req_dropped", {31'd0, MEM_REQ}, 32'd0);
        MREQ_n = 1'b1; nRD = 1'b1; nWR = 1'b1;
        repeat (4) @(negedge CLK_24M);
    endtask

    initial begin
        int          low;
        int          pul;
        logic        lp;
        logic [17:0] p_seen;
        logic [17:0] n_seen;
        bit          saw_req;
        bit          saw_wait;

        REGION_BASE = {16'hF800, 16'h0000};
        REGION_MASK = {16'hF800, 16'hC000};
        REGION_WS   = {4'd3, 4'd0};

        // Reset state
        #23;
        check_eq("rst_p_en", {31'd0, CLK_P_EN}, 32'd0);
        check_eq("rst_n_en", {31'd0, CLK_N_EN}, 32'd0);
        check_eq("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
        check_eq("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        check_eq("rst_mem_addr", {16'd0, MEM_ADDR}, 32'h0);
        check_eq("rst_mem_wdata", {24'd0, MEM_WDATA}, 32'h0);
        check_eq("rst_sdd_in", {24'd0, SDD_IN}, 32'hFF);
        check_eq("rst_nwait", {31'd0, nWAIT}, 32'd1);

        // Divider phases after release
        @(negedge CLK_24M);
        nRESET = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CLK_24M);
            p_seen[k] = CLK_P_EN;
            n_seen[k] = CLK_N_EN;
        end
        check_eq("div_p_en", {14'd0, p_seen}, {14'd0, 18'b000001000001000001});
        check_eq("div_n_en", {14'd0, n_seen}, {14'd0, 18'b001000001000001000});

        // Refresh cycles are masked, with RD high and then (defensively) low
        SDA = 16'h1234; MREQ_n = 1'b0; RFSH_n = 1'b0; nRD = 1'b1; nWR = 1'b1;
        #1;
        check_eq("rfsh_nmreq", {31'd0, nMREQ}, 32'd1);
        saw_req = 0; saw_wait = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) nRD = 1'b0;
            @(negedge CLK_24M);
            if (MEM_REQ) saw_req = 1;
            if (!nWAIT) saw_wait = 1;
        end
        check_eq("rfsh_no_req", {31'd0, saw_req}, 32'd0);
        check_eq("rfsh_no_wait", {31'd0, saw_wait}, 32'd0);
        MREQ_n = 1'b1; RFSH_n = 1'b1; nRD = 1'b1;
        #1;
        check_eq("idle_nmreq", {31'd0, nMREQ}, 32'd1);
        repeat (3) @(negedge CLK_24M);

        // Zero-wait read, ACK two cycles after MEM_REQ
        run_txn(16'h1234, 1'b0, 8'h00, 2, 8'h5A, low, pul, lp);
        check_eq("zw_low_cycles", low, 32'd3);
        check_eq("zw_addr", {16'd0, MEM_ADDR}, 32'h1234);
        check_eq("zw_we", {31'd0, MEM_WE}, 32'd0);
        check_eq("zw_sdd_in", {24'd0, SDD_IN}, 32'h5A);

        // Write to 3-wait region with immediate ACK: minimum dominates
        run_txn(16'hF801, 1'b1, 8'hA5, 0, 8'hEE, low, pul, lp);
        check_eq("ws_pulses", pul, 32'd3);
        check_eq("ws_release_on_pulse", {31'd0, lp}, 32'd1);
        check_eq("ws_we", {31'd0, MEM_WE}, 32'd1);
        check_eq("ws_wdata", {24'd0, MEM_WDATA}, 32'hA5);
        check_eq("ws_addr", {16'd0, MEM_ADDR}, 32'hF801);
        check_eq("ws_sdd_in_kept", {24'd0, SDD_IN}, 32'h5A);

        // Overlapping regions: region 0 (WS=1) wins over region 1 (WS=3); ACK on the final decrement
        REGION_BASE = {16'hF800, 16'hF800};
        REGION_MASK = {16'hF800, 16'hF800};
        REGION_WS   = {4'd3, 4'd1};
        run_txn(16'hF800, 1'b0, 8'h00, -1, 8'h3C, low, pul, lp);
        check_eq("ovl_pulses", pul, 32'd1);
        check_eq("ovl_direct_done", {31'd0, lp}, 32'd1);
        check_eq("ovl_sdd_in", {24'd0, SDD_IN}, 32'h3C);

        // Reset while MEM_REQ is high, then a stale ACK
        REGION_BASE = {16'hF800, 16'h0000};
        REGION_MASK = {16'hF800, 16'hC000};
        REGION_WS   = {4'd3, 4'd0};
        @(negedge CLK_24M);
        SDA = 16'h0100; MREQ_n = 1'b0; nRD = 1'b0;
        begin
            int t;
            t = 0;
            while (!MEM_REQ && t < 20) begin
                @(negedge CLK_24M);
                t++;
            end
        end
        check_eq("mid_req_up", {31'd0, MEM_REQ}, 32'd1);
        nRESET = 1'b0;
        #1;
        check_eq("mid_req_async", {31'd0, MEM_REQ}, 32'd0);
        check_eq("mid_nwait_async", {31'd0, nWAIT}, 32'd1);
        MREQ_n = 1'b1; nRD = 1'b1;
        repeat (2) @(negedge CLK_24M);
        nRESET = 1'b1;
        @(negedge CLK_24M);
        MEM_ACK = 1'b1; MEM_RDATA = 8'h77;
        @(negedge CLK_24M);
        MEM_ACK = 1'b0;
        repeat (2) @(negedge CLK_24M);
        check_eq("stale_sdd_in", {24'd0, SDD_IN}, 32'hFF);
        check_eq("stale_req", {31'd0, MEM_REQ}, 32'd0);
        check_eq("stale_nwait", {31'd0, nWAIT}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
